// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle right shifter: FSM states,
// per-cycle step limit and the MIPS funct codes it serves.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int STEP_MAX = 8;
  // Wide enough to carry any per-cycle shift amount 0..STEP_MAX.
  localparam int K_W = 4;

  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

endpackage

// File: rtl/shift_right_step.sv
// One combinational right-shift step of 0..STEP_MAX bits, vacated
// positions filled with fill_bit.
module shift_right_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [K_W-1:0]   k,
  input  logic             fill_bit,
  output logic [WIDTH-1:0] data_out
);

  // Shifting a double-width word keeps the fill bits on the left edge.
  always_comb begin
    data_out = WIDTH'({{WIDTH{fill_bit}}, data_in} >> k);
  end

endmodule

// File: rtl/seq_shift_right.sv
// Multi-cycle SRL/SRA/SRLV/SRAV unit: captures an operand, shifts it up to
// STEP bits per clock, then holds the result until the consumer takes it.
module seq_shift_right
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] STEP_S = SHAMT_W'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               arith_q, arith_d;
  logic [SHAMT_W-1:0] k;
  logic               last_step;
  logic               fill_bit;
  logic [WIDTH-1:0]   step_out;

  always_comb begin
    k         = (rem_q < STEP_S) ? rem_q : STEP_S;
    last_step = (rem_q <= STEP_S);
    fill_bit  = arith_q & data_q[WIDTH-1];
  end

  shift_right_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data_in (data_q),
    .k       (K_W'(k)),
    .fill_bit(fill_bit),
    .data_out(step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      out_data_q <= '0;
      rem_q      <= '0;
      arith_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      rem_q      <= rem_d;
      arith_q    <= arith_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (in_shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // out_data has its own register so it only changes when a result lands.
  always_comb begin
    data_d     = data_q;
    out_data_d = out_data_q;
    rem_d      = rem_q;
    arith_d    = arith_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_shamt;
          arith_d = in_arith;
          if (in_shamt == '0) out_data_d = in_data;
        end
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = rem_q - k;
        if (last_step) out_data_d = step_out;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = out_data_q;
  end

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed bench for seq_shift_right: a STEP=1 and a STEP=4 instance driven
// from a vector table plus hand-written backpressure/reset/handshake sequences.
module tb_seq_shift_right;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [W-1:0]  in_data   [2];
  logic [SW-1:0] in_shamt  [2];
  logic          in_arith  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [W-1:0]  out_data  [2];
  logic          busy      [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shift_right #(.WIDTH(W), .SHAMT_W(SW), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_shamt(in_shamt[0]), .in_arith(in_arith[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  seq_shift_right #(.WIDTH(W), .SHAMT_W(SW), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_shamt(in_shamt[1]), .in_arith(in_arith[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input int sel, input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready[sel]), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid[sel]), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy[sel]), 32'd0);
  endtask

  // Called just after a negedge; returns #1 after the accept edge.
  task automatic applyStimulus(input int sel, input logic [31:0] d, input logic [4:0] sh,
                               input logic a, input bit hold);
    checkOutput("accept_ready", 32'(in_ready[sel]), 32'd1);
    in_data[sel]  = d;
    in_shamt[sel] = sh;
    in_arith[sel] = a;
    in_valid[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid[sel] = 1'b0;
  endtask

  // Latency counts the accept edge as 1; bounded so a stuck DUT still ends.
  task automatic waitResult(input int sel, output int lat);
    lat = 1;
    while (!out_valid[sel] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire(input int sel);
    @(negedge clk);
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[sel] = 1'b0;
    checkIdle(sel, "retire");
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    @(negedge clk);
    applyStimulus(v.sel, v.data, v.shamt, v.arith, 1'b0);
    checkOutput("busy_after_accept", 32'(busy[v.sel]), 32'd1);
    waitResult(v.sel, lat);
    checkOutput("latency", 32'(lat), 32'(v.exp_lat));
    checkOutput("result", out_data[v.sel], v.exp_data);
    retire(v.sel);
  endtask

  initial begin
    int lat;

    vecs[0] = '{0, 32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000, 5};
    vecs[1] = '{0, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32};
    vecs[2] = '{0, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32};
    vecs[3] = '{1, 32'hFFFF_0000, 5'd10, 1'b1, 32'hFFFF_FFC0, 4};
    vecs[4] = '{0, 32'h1234_5678, 5'd8,  1'b0, 32'h0012_3456, 9};
    vecs[5] = '{1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 9};
    vecs[6] = '{1, 32'h7FFF_FFFF, 5'd5,  1'b1, 32'h03FF_FFFF, 3};
    vecs[7] = '{0, 32'hA5A5_A5A5, 5'd1,  1'b1, 32'hD2D2_D2D2, 2};
    vecs[8] = '{1, 32'h0000_ABCD, 5'd0,  1'b0, 32'h0000_ABCD, 1};
    vecs[9] = '{1, 32'hF000_0000, 5'd8,  1'b0, 32'h00F0_0000, 3};

    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      in_data[s]   = '0;
      in_shamt[s]  = '0;
      in_arith[s]  = 1'b0;
      out_ready[s] = 1'b0;
    end

    // Reset then idle.
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkIdle(s, "reset");
      checkOutput("reset_out_data", out_data[s], 32'h0);
    end

    for (int i = 0; i < 10; i++) runVector(vecs[i]);

    // Zero shift held under backpressure for 10 cycles.
    @(negedge clk);
    applyStimulus(0, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      checkOutput("bp_out_valid", 32'(out_valid[0]), 32'd1);
      checkOutput("bp_out_data", out_data[0], 32'h1234_5678);
      @(posedge clk);
      #1;
    end
    retire(0);
    checkOutput("hold_after_retire", out_data[0], 32'h1234_5678);

    // Reset mid-SHIFT aborts asynchronously.
    @(negedge clk);
    applyStimulus(0, 32'hFFFF_FFFF, 5'd20, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("midshift_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkIdle(0, "async_reset");
    checkOutput("async_reset_out_data", out_data[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh request with in_valid held and inputs changed during SHIFT.
    @(negedge clk);
    applyStimulus(0, 32'hF0F0_F0F0, 5'd4, 1'b1, 1'b1);
    in_data[0]  = 32'h0000_0000;
    in_shamt[0] = 5'd0;
    in_arith[0] = 1'b0;
    checkOutput("held_in_ready", 32'(in_ready[0]), 32'd0);
    waitResult(0, lat);
    checkOutput("held_latency", 32'(lat), 32'd5);
    checkOutput("held_result", out_data[0], 32'hFF0F_0F0F);
    in_valid[0] = 1'b0;
    retire(0);

    // Retire and new request in the same cycle: no bypass.
    @(negedge clk);
    applyStimulus(1, 32'h1111_1111, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    in_data[1]   = 32'h2222_2222;
    in_shamt[1]  = 5'd4;
    in_arith[1]  = 1'b0;
    in_valid[1]  = 1'b1;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[1] = 1'b0;
    checkIdle(1, "no_bypass");
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    waitResult(1, lat);
    checkOutput("after_bypass_latency", 32'(lat), 32'd2);
    checkOutput("after_bypass_result", out_data[1], 32'h0222_2222);
    retire(1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
